// File: rtl/rgb_pwm_fader.sv
// rtl/rgb_pwm_fader.sv - RGB PWM generator with linear colour fades
//
// Purpose: drives the three SB_RGBA_DRV PWM inputs. A target colour is taken
// over a valid/ready handshake and every channel ramps one LSB per STEP_DIV
// clocks toward it. Duty updates are applied only at PWM period boundaries,
// so the LED outputs never glitch.
//
// Build option: define RGB_PWM_FADER_GAMMA_EN to pass each channel through
// a square-law gamma map (c*(c+1) >> PWM_BITS) before it reaches the
// comparator. Without it, the duty equals the current channel value.
//
// Ports:
//   hw_clk      clock, all logic on posedge
//   rst         synchronous active-high reset
//   tgt_valid   target colour offered
//   tgt_ready   target can be accepted (IDLE and not in reset)
//   tgt_red     target red duty   [PWM_BITS]
//   tgt_blue    target blue duty  [PWM_BITS]
//   tgt_green   target green duty [PWM_BITS]
//   pwm_red     to RGB0PWM
//   pwm_blue    to RGB1PWM
//   pwm_green   to RGB2PWM
//   busy        fade in progress (FADE or DONE)
//   done        one-cycle pulse when all channels reached the target
module rgb_pwm_fader #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 48000
) (
  input  logic                hw_clk,
  input  logic                rst,
  input  logic                tgt_valid,
  output logic                tgt_ready,
  input  logic [PWM_BITS-1:0] tgt_red,
  input  logic [PWM_BITS-1:0] tgt_blue,
  input  logic [PWM_BITS-1:0] tgt_green,
  output logic                pwm_red,
  output logic                pwm_blue,
  output logic                pwm_green,
  output logic                busy,
  output logic                done
);

  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  // Counter stops one short of all-ones so a full-scale duty is constant high.
  localparam logic [PWM_BITS-1:0] CNT_LAST  = PWM_BITS'((1 << PWM_BITS) - 2);
  localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FADE = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Channel index: 0 = red, 1 = blue, 2 = green.
  state_t                       state_q, state_d;
  logic [2:0][PWM_BITS-1:0]     cur_q, cur_d;
  logic [2:0][PWM_BITS-1:0]     tgt_q, tgt_d;
  logic [SW-1:0]                step_cnt_q, step_cnt_d;
  logic [PWM_BITS-1:0]          pwm_cnt_q;
  logic [2:0][PWM_BITS-1:0]     duty_q;
  logic [2:0]                   pwm_q;

  function automatic logic [PWM_BITS-1:0] map_duty(input logic [PWM_BITS-1:0] c);
`ifdef RGB_PWM_FADER_GAMMA_EN
    logic [2*PWM_BITS-1:0] c_w;
    logic [2*PWM_BITS-1:0] prod;
    c_w  = {{PWM_BITS{1'b0}}, c};
    // c*(c+1) keeps full scale at full scale, unlike c*c.
    prod = c_w * (c_w + {{(2*PWM_BITS-1){1'b0}}, 1'b1});
    return prod[2*PWM_BITS-1:PWM_BITS];
`else
    return c;
`endif
  endfunction

  // One LSB toward the target; equal channels hold, so no overshoot or wrap.
  function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] c,
                                                      input logic [PWM_BITS-1:0] t);
    if (c < t)      return c + PWM_BITS'(1);
    else if (c > t) return c - PWM_BITS'(1);
    else            return c;
  endfunction

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    tgt_d      = tgt_q;
    step_cnt_d = step_cnt_q;
    tgt_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tgt_ready = 1'b1;
        if (tgt_valid) begin
          tgt_d      = {tgt_green, tgt_blue, tgt_red};
          step_cnt_d = '0;
          state_d    = S_FADE;
        end
      end
      S_FADE: begin
        busy = 1'b1;
        // Equality is checked before stepping, so a no-op target still
        // passes through DONE one cycle later.
        if (cur_q == tgt_q) begin
          state_d = S_DONE;
        end else if (step_cnt_q == STEP_LAST) begin
          step_cnt_d = '0;
          for (int i = 0; i < 3; i++) begin
            cur_d[i] = step_toward(cur_q[i], tgt_q[i]);
          end
        end else begin
          step_cnt_d = step_cnt_q + SW'(1);
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) tgt_ready = 1'b0;
  end

  always_ff @(posedge hw_clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      tgt_q      <= '0;
      step_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      duty_q     <= '0;
      pwm_q      <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      tgt_q      <= tgt_d;
      step_cnt_q <= step_cnt_d;
      if (pwm_cnt_q == CNT_LAST) begin
        pwm_cnt_q <= '0;
        // Duty only changes at the wrap, so each period is whole.
        for (int i = 0; i < 3; i++) begin
          duty_q[i] <= map_duty(cur_q[i]);
        end
      end else begin
        pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      end
      for (int i = 0; i < 3; i++) begin
        pwm_q[i] <= (pwm_cnt_q < duty_q[i]);
      end
    end
  end

  assign pwm_red   = pwm_q[0];
  assign pwm_blue  = pwm_q[1];
  assign pwm_green = pwm_q[2];

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// tb/tb_rgb_pwm_fader.sv - directed scoreboard bench for rgb_pwm_fader
module tb_rgb_pwm_fader;

  localparam int PB = 8;
  localparam int SD = 4;

  logic          hw_clk = 1'b0;
  logic          rst = 1'b1;
  logic          tgt_valid = 1'b0;
  logic          tgt_ready;
  logic [PB-1:0] tgt_red = '0;
  logic [PB-1:0] tgt_blue = '0;
  logic [PB-1:0] tgt_green = '0;
  logic          pwm_red, pwm_blue, pwm_green, busy, done;

  rgb_pwm_fader #(.PWM_BITS(PB), .STEP_DIV(SD)) dut (
    .hw_clk    (hw_clk),
    .rst       (rst),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .tgt_red   (tgt_red),
    .tgt_blue  (tgt_blue),
    .tgt_green (tgt_green),
    .pwm_red   (pwm_red),
    .pwm_blue  (pwm_blue),
    .pwm_green (pwm_green),
    .busy      (busy),
    .done      (done)
  );

  always #5 hw_clk = ~hw_clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int exp_q[$];
  int cur_m[3];

  function automatic int exp_duty(input int c);
`ifdef RGB_PWM_FADER_GAMMA_EN
    return (c * (c + 1)) >> PB;
`else
    return c;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_pop(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) check({tag, "_noexp"}, obs, 32'hdead_beef);
    else check(tag, obs, exp_q.pop_front());
  endtask

  // Called at a negedge while IDLE; returns at the negedge after the accept edge.
  task automatic accept(input int r, input int b, input int g);
    int t[3];
    int maxd;
    t = '{r, b, g};
    maxd = 0;
    for (int i = 0; i < 3; i++) begin
      int d;
      d = (t[i] > cur_m[i]) ? t[i] - cur_m[i] : cur_m[i] - t[i];
      if (d > maxd) maxd = d;
      cur_m[i] = t[i];
    end
    exp_q.push_back(SD * maxd + 1);
    tgt_red = PB'(r); tgt_blue = PB'(b); tgt_green = PB'(g);
    tgt_valid = 1'b1;
    check("acc_ready", tgt_ready, 1);
    @(negedge hw_clk);
    tgt_valid = 1'b0;
    check("acc_busy", busy, 1);
  endtask

  // Waits for done; optionally offers a bogus target for 40 cycles mid-fade.
  task automatic wait_done(input string tag, input int limit, input int inj_at);
    int lat;
    int rdy_hi;
    lat = -1;
    rdy_hi = 0;
    for (int k = 1; k <= limit; k++) begin
      @(negedge hw_clk);
      if (tgt_ready) rdy_hi++;
      if (done) begin
        lat = k;
        break;
      end
      if (inj_at > 0 && k == inj_at) begin
        tgt_red = 8'd255; tgt_blue = 8'd255; tgt_green = 8'd255;
        tgt_valid = 1'b1;
      end
      if (inj_at > 0 && k == inj_at + 40) tgt_valid = 1'b0;
    end
    tgt_valid = 1'b0;
    check_pop({tag, "_latency"}, lat);
    check({tag, "_ready_low"}, rdy_hi, 0);
    @(negedge hw_clk);
    check({tag, "_post_done"}, {done, busy, tgt_ready}, 3'b001);
  endtask

  task automatic measure(input string tag);
    int hi[3];
    for (int i = 0; i < 3; i++) exp_q.push_back(exp_duty(cur_m[i]));
    hi = '{0, 0, 0};
    repeat (300) @(negedge hw_clk);
    repeat (255) begin
      @(negedge hw_clk);
      hi[0] += int'(pwm_red);
      hi[1] += int'(pwm_blue);
      hi[2] += int'(pwm_green);
    end
    check_pop({tag, "_red_high"}, hi[0]);
    check_pop({tag, "_blue_high"}, hi[1]);
    check_pop({tag, "_green_high"}, hi[2]);
  endtask

  initial begin
    int pwm_hi, busy_hi, rdy_lo, done_cnt;
    cur_m = '{0, 0, 0};

    rst = 1'b1;
    repeat (3) @(negedge hw_clk);
    check("rst_ready", tgt_ready, 0);
    check("rst_outputs", {pwm_red, pwm_blue, pwm_green, busy, done}, 0);
    rst = 1'b0;
    @(negedge hw_clk);
    check("ready_after_rst", tgt_ready, 1);
    check("busy_after_rst", busy, 0);
    pwm_hi = 0; busy_hi = 0; rdy_lo = 0;
    repeat (600) begin
      @(negedge hw_clk);
      pwm_hi  += int'(pwm_red | pwm_blue | pwm_green);
      busy_hi += int'(busy);
      rdy_lo  += int'(!tgt_ready);
    end
    check("idle_pwm", pwm_hi, 0);
    check("idle_busy", busy_hi, 0);
    check("idle_ready_low", rdy_lo, 0);

    accept(255, 0, 0);
    wait_done("full_red", 1100, 0);
    measure("full_red");

    accept(10, 0, 0);
    wait_done("red10", 1100, 0);
    measure("red10");
    accept(10, 0, 0);
    wait_done("red10_again", 20, 0);
    measure("red10_again");

    accept(200, 100, 50);
    wait_done("mix_a", 900, 0);
    accept(190, 110, 50);
    wait_done("mix_b", 100, 0);
    measure("mix_b");

    accept(0, 0, 0);
    wait_done("ignore_valid", 900, 100);
    measure("ignore_valid");

    accept(128, 0, 0);
    wait_done("half_red", 600, 0);
    measure("half_red");

    accept(100, 100, 100);
    repeat (200) @(negedge hw_clk);
    rst = 1'b1;
    @(negedge hw_clk);
    check("midrst_outputs", {pwm_red, pwm_blue, pwm_green, busy, done}, 0);
    check("midrst_ready", tgt_ready, 0);
    rst = 1'b0;
    exp_q.delete();
    cur_m = '{0, 0, 0};
    pwm_hi = 0; done_cnt = 0;
    repeat (300) begin
      @(negedge hw_clk);
      pwm_hi   += int'(pwm_red | pwm_blue | pwm_green);
      done_cnt += int'(done);
    end
    check("midrst_no_done", done_cnt, 0);
    check("midrst_dark", pwm_hi, 0);
    check("midrst_ready_back", tgt_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
